// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - shared defaults and helpers for the stochastic variable node
package stoch_pkg;

  localparam int DEF_DV     = 3;
  localparam int DEF_EM_LEN = 32;
  localparam int DEF_AW     = $clog2(DEF_EM_LEN);

  // True when every bit selected by care has the same value; unselected bits are ignored.
  function automatic logic all_equal(input logic [31:0] bits, input logic [31:0] care);
    return (&(bits | ~care)) | (&(~bits | ~care));
  endfunction

endpackage

// File: rtl/stoch_var_node_if.sv
// rtl/stoch_var_node_if.sv - decoding-cycle bus between the decoder core and a variable node
interface stoch_var_node_if
  import stoch_pkg::*;
#(
  parameter int DV = DEF_DV,
  parameter int AW = DEF_AW
) ();

  logic          EN;
  logic          CH_BIT;
  logic [DV-1:0] CN_BITS;
  logic [DV*AW-1:0] RAND;
  logic [DV-1:0] VN_BITS;
  logic          DEC_BIT;

  modport master (
    output EN, CH_BIT, CN_BITS, RAND,
    input  VN_BITS, DEC_BIT
  );

  modport slave (
    input  EN, CH_BIT, CN_BITS, RAND,
    output VN_BITS, DEC_BIT
  );

endinterface

// File: rtl/vn_edge_mem.sv
// rtl/vn_edge_mem.sv - one edge of the variable node: edge memory, fill counter, registered edge bit
module vn_edge_mem #(
  parameter int EM_LEN = 32,
  parameter int AW     = 5
) (
  input  logic          CLK,
  input  logic          INIT_N,
  input  logic          EN,
  input  logic          WE,
  input  logic          WDATA,
  input  logic [AW-1:0] RAND,
  input  logic          CH_BIT,
  output logic          EDGE_BIT
);

  localparam logic [AW:0] FULL = (AW+1)'(EM_LEN);

  logic [EM_LEN-1:0] em;
  logic [AW:0]       fill;
  logic              rd_bit;

  // Read from pre-shift contents; addresses beyond the filled region fall back to the newest bit.
  always_comb begin
    if (fill == '0) begin
      rd_bit = CH_BIT;
    end else if ({1'b0, RAND} < fill) begin
      rd_bit = em[RAND];
    end else begin
      rd_bit = em[0];
    end
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      em       <= '0;
      fill     <= '0;
      EDGE_BIT <= 1'b0;
    end else if (EN) begin
      if (WE) begin
        EDGE_BIT <= WDATA;
        em       <= {em[EM_LEN-2:0], WDATA};
        if (fill != FULL) begin
          fill <= fill + (AW+1)'(1);
        end
      end else begin
        EDGE_BIT <= rd_bit;
      end
    end
  end

endmodule

// File: rtl/stoch_var_node.sv
// rtl/stoch_var_node.sv - degree-DV stochastic variable node with per-edge edge memories
module stoch_var_node
  import stoch_pkg::*;
#(
  parameter int DV     = DEF_DV,
  parameter int EM_LEN = DEF_EM_LEN,
  parameter int AW     = DEF_AW
) (
  input logic              CLK,
  input logic              INIT_N,
  stoch_var_node_if.slave  bus
);

  localparam logic [DV:0] CARE_ALL = '1;

  logic [DV:0]   in_bits;
  logic [DV-1:0] agree;
  logic [DV-1:0] vn;
  logic          dec_agree;
  logic          dec_h;

  assign in_bits = {bus.CN_BITS, bus.CH_BIT};

  genvar e;
  for (e = 0; e < DV; e++) begin : g_edge
    // Edge e ignores its own check-node bit, which sits at in_bits[e+1].
    localparam logic [DV:0] CARE = ~((DV+1)'(1) << (e + 1));

    assign agree[e] = all_equal(32'(in_bits), 32'(CARE));

    vn_edge_mem #(
      .EM_LEN (EM_LEN),
      .AW     (AW)
    ) u_mem (
      .CLK      (CLK),
      .INIT_N   (INIT_N),
      .EN       (bus.EN),
      .WE       (agree[e]),
      .WDATA    (bus.CH_BIT),
      .RAND     (bus.RAND[e*AW +: AW]),
      .CH_BIT   (bus.CH_BIT),
      .EDGE_BIT (vn[e])
    );
  end

  assign dec_agree = all_equal(32'(in_bits), 32'(CARE_ALL));

  // The hold register and the decision output always carry the same value, so one flop serves both.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      dec_h <= 1'b0;
    end else if (bus.EN && dec_agree) begin
      dec_h <= bus.CH_BIT;
    end
  end

  assign bus.VN_BITS = vn;
  assign bus.DEC_BIT = dec_h;

endmodule

// File: tb/tb_stoch_var_node.sv
// tb/tb_stoch_var_node.sv - scoreboard bench for stoch_var_node with directed vectors
module tb_stoch_var_node;

  logic CLK = 1'b0;
  logic INIT_N;

  always #5 CLK = ~CLK;

  stoch_var_node_if #(.DV(3), .AW(5)) bus ();

  stoch_var_node #(.DV(3), .EM_LEN(32), .AW(5)) dut (
    .CLK    (CLK),
    .INIT_N (INIT_N),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0] vn;
    logic       dec;
    string      name;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] rp(input int r0, input int r1, input int r2);
    return {5'(r2), 5'(r1), 5'(r0)};
  endfunction

  // One decoding cycle: drive away from the rising edge and queue the expected registered response.
  task automatic step(input logic en, input logic ch, input logic [2:0] cn, input logic [14:0] rnd,
                      input logic [2:0] exp_vn, input logic exp_dec, input string name);
    exp_t x;
    @(negedge CLK);
    bus.EN      = en;
    bus.CH_BIT  = ch;
    bus.CN_BITS = cn;
    bus.RAND    = rnd;
    x.vn = exp_vn;
    x.dec = exp_dec;
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge CLK);
    #1;
    bus.EN = 1'b0;
    INIT_N = 1'b0;
    #1;
    chk({name, "_vn"}, 32'(bus.VN_BITS), 32'd0);
    chk({name, "_dec"}, 32'(bus.DEC_BIT), 32'd0);
    #1;
    INIT_N = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge CLK);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk({x.name, "_vn"}, 32'(bus.VN_BITS), 32'(x.vn));
        chk({x.name, "_dec"}, 32'(bus.DEC_BIT), 32'(x.dec));
      end
    end
  end

  initial begin : driver
    INIT_N      = 1'b0;
    bus.EN      = 1'b0;
    bus.CH_BIT  = 1'b0;
    bus.CN_BITS = '0;
    bus.RAND    = '0;
    #3;
    chk("reset_vn", 32'(bus.VN_BITS), 32'd0);
    chk("reset_dec", 32'(bus.DEC_BIT), 32'd0);
    pulse_reset("reset_pulse");

    // First cycle after reset: every edge disagrees with fill 0, so it echoes CH_BIT.
    step(1, 1, 3'b010, rp(0, 0, 0), 3'b111, 1'b0, "first");

    // Long regenerative run pushes fill past EM_LEN; a 6-bit wrap would land exactly on 0.
    for (int i = 0; i < 64; i++) step(1, 1, 3'b111, rp(0, 0, 0), 3'b111, 1'b1, "regen");
    step(1, 0, 3'b011, rp(5, 31, 20), 3'b111, 1'b1, "sat_hold");

    // Pattern 1,0,1,1 leaves EM[0..3] = 1,1,0,1 with fill 4 on every edge.
    pulse_reset("reset2");
    step(1, 1, 3'b111, rp(0, 0, 0), 3'b111, 1'b1, "wr1");
    step(1, 0, 3'b000, rp(0, 0, 0), 3'b000, 1'b0, "wr0");
    step(1, 1, 3'b111, rp(0, 0, 0), 3'b111, 1'b1, "wr1b");
    step(1, 1, 3'b111, rp(0, 0, 0), 3'b111, 1'b1, "wr1c");
    step(1, 0, 3'b011, rp(2, 3, 1), 3'b110, 1'b1, "hold_a");
    step(1, 1, 3'b100, rp(9, 4, 2), 3'b011, 1'b1, "hold_b");
    step(1, 0, 3'b011, rp(3, 2, 3), 3'b101, 1'b1, "hold_c");

    // EN low with inputs that would otherwise write: nothing moves.
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step(0, 1, 3'b111, rp(i, i, i), 3'b101, 1'b1, "en_gate");
      else            step(0, 0, 3'b000, rp(i, i, i), 3'b101, 1'b1, "en_gate");
    end
    step(1, 0, 3'b011, rp(4, 2, 3), 3'b101, 1'b1, "en_resume");
    step(1, 1, 3'b100, rp(2, 3, 2), 3'b010, 1'b1, "en_resume2");

    // Asynchronous reset between edges after a regenerative run.
    pulse_reset("reset3");
    for (int i = 0; i < 20; i++) step(1, 1, 3'b111, rp(0, 0, 0), 3'b111, 1'b1, "regen20");
    @(posedge CLK);
    #3;
    bus.EN = 1'b0;
    INIT_N = 1'b0;
    #1;
    chk("async_vn", 32'(bus.VN_BITS), 32'd0);
    chk("async_dec", 32'(bus.DEC_BIT), 32'd0);
    #1;
    INIT_N = 1'b1;
    step(1, 1, 3'b100, rp(5, 5, 5), 3'b111, 1'b0, "post_rst_a");
    step(1, 0, 3'b011, rp(5, 5, 5), 3'b000, 1'b0, "post_rst_b");

    // Mixed: edge 0 agrees on 0 while edges 1 and 2 hold.
    step(1, 1, 3'b111, rp(0, 0, 0), 3'b111, 1'b1, "mix_pre");
    step(1, 0, 3'b001, rp(0, 0, 7), 3'b110, 1'b1, "mix");
    step(1, 1, 3'b100, rp(0, 1, 1), 3'b110, 1'b1, "mix_after");

    @(negedge CLK);
    bus.EN = 1'b0;
    repeat (3) @(posedge CLK);
    #4;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stoch_var_node.md
# stoch_var_node

Degree-DV stochastic variable node with per-edge edge memories (EM) for the stochastic LDPC decoder. Each clock it consumes one channel stochastic bit and DV check-node bits, produces DV extrinsic bits back to the check nodes, and produces one decision bit stream. The decision stream drives the up/down hard-decision counter directly downstream: 1 counts up, 0 counts down.

## Interface
Parameters:
- DV, 3: variable-node degree (number of edges), ≥2
- EM_LEN, 32: edge-memory depth per edge, power of two
- AW, 5: address width, log2(EM_LEN)

Ports:
- CLK  in  1  clock, rising edge
- INIT_N  in  1  asynchronous active-low reset
- EN  in  1  decoding-cycle enable; when low all state holds
- CH_BIT  in  1  channel stochastic bit
- CN_BITS  in  DV  incoming check-node bits, bit e = edge e
- RAND  in  DV*AW  random read addresses from the shared LFSR bank, slice [e*AW +: AW] = edge e
- VN_BITS  out  DV  outgoing extrinsic bits, bit e = edge e
- DEC_BIT  out  1  decision bit to the hard-decision counter

## Operation
- Edge e uses CH_BIT and CN_BITS excluding bit e (DV inputs in total).
- **Regenerative (agree):** all DV inputs are equal to value v.
  - VN_BITS[e] <= v.
  - EM_e shifts: EM_e[0] <= v, EM_e[k] <= EM_e[k-1].
  - fill_e <= min(fill_e+1, EM_LEN).
- **Hold (disagree):** EM_e and fill_e do not change. VN_BITS[e] is selected as follows:
  - if fill_e == 0: CH_BIT
  - else if RAND_e < fill_e: EM_e[RAND_e]
  - else: EM_e[0] (most recent entry)
- The read always uses the pre-shift contents for the current cycle. A hold never writes.
- **Decision:** if CH_BIT and all DV CN_BITS are equal to v, DEC_BIT <= v and the hold register dec_h <= v. Otherwise DEC_BIT <= dec_h.
- fill_e is an AW+1-bit counter that saturates at EM_LEN and never wraps. Once full, the EM behaves as a pure shift register and the oldest bit is discarded.
- EN low: no shift, no fill change, outputs hold their last value, RAND is ignored.
- Edges are fully independent. Simultaneous regenerative and hold across different edges in the same cycle is normal.

## Timing
- Reset (INIT_N low, asynchronous, takes effect at any time including mid-decode):
  - all EM bits 0, all fill_e 0, dec_h 0
  - VN_BITS = 0, DEC_BIT = 0
- Release is synchronous to the next CLK edge. The first enabled edge after release behaves as fill = 0.
- Latency: one cycle. Inputs sampled at edge n with EN=1 appear on VN_BITS/DEC_BIT after edge n.
- There is no combinational path from any input to any output.
- Throughput: one decoding cycle per CLK when EN=1. No backpressure.

## Structure
- Shared package `stoch_pkg`: default DV, EM_LEN, AW = $clog2(EM_LEN), and a function returning the "all-equal" flag over a bit vector.
- Sub-module `vn_edge_mem`, instantiated DV times via generate. It contains:
  - ports: CLK, INIT_N, EN, write-enable (agree), write data (v), RAND slice, CH_BIT
  - fill counter, shift register and read mux
  - output: the registered edge bit
- The top level holds only the exclusion wiring, the agree logic and the decision register.

## Test plan
- Reset then first cycle: INIT_N pulse, EN=1, CH_BIT=1, CN_BITS=3'b010 (edge 0 sees 1,1,0 → hold, fill 0) → VN_BITS[0]=1 (CH_BIT), DEC_BIT=0 (dec_h reset).
- Regenerative fill: CH_BIT=1, CN_BITS=3'b111 for 40 cycles → VN_BITS=3'b111, DEC_BIT=1 every cycle, each fill_e saturates at 32 and does not wrap.
- Hold read-back: write pattern 1,0,1,1 into EM_0 (EM_0[0..3]=1,1,0,1), then disagree with RAND_0=2 → VN_BITS[0]=0. RAND_0=9 with fill=4 → VN_BITS[0]=EM_0[0]=1. EM contents unchanged.
- EN gating: EN=0 for 5 cycles with toggling inputs → outputs, fill and EM frozen. EN=1 resumes with identical state.
- Async reset mid-decode: INIT_N low between clock edges after 20 regenerative cycles → VN_BITS=0 and DEC_BIT=0 immediately, without waiting for CLK. Fill back to 0 (the next hold returns CH_BIT).
- Mixed edges: CH_BIT=0, CN_BITS=3'b001 → edge 0 agree (writes 0), edges 1 and 2 hold. Only EM_0 shifts, and DEC_BIT takes dec_h.
